keypad_event_encoder: RTL and testbench
=======================================

# keypad_event_encoder

Parametrised keypad front-end for the microwave controller: priority-encodes an N-key pad, debounces the selected key with an internal counter, and delivers exactly one key event per press through a valid/ready handshake. It also generates a divided timing tick and muxes tick or accept-strobe onto a single strobe output. It sits between the raw keypad pins and the time-entry/display logic. It generalises the fixed 10-key, fixed-divide encoder to configurable key count, debounce length and divide ratio, and adds buffering and handshaking.

## Interface
- NUM_KEYS, 10, number of key inputs (≥2)
- CODE_W, 4, width of key_code (≥ $clog2(NUM_KEYS))
- DEBOUNCE_CYCLES, 100, consecutive stable cycles for press/release (≥1)
- TICK_DIV, 100, clock divide ratio for tick (≥2)
- REPEAT_CYCLES, 1000, hold time before auto-repeat (used only with KEYPAD_REPEAT_EN)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- keypad  in  NUM_KEYS  raw key lines, 1 = pressed; pre-synchronised externally
- enable_n  in  1  active-low scan enable
- key_ready  in  1  consumer accepts event
- key_valid  out  1  event pending
- key_code  out  CODE_W  index of the event key, stable while key_valid
- any_key  out  1  OR of keypad, combinational
- tick  out  1  one-cycle pulse every TICK_DIV cycles
- strobe_out  out  1  enable_n ? tick : (key_valid & key_ready)

## Operation
- Encoder: highest set index wins, so keys 2 and 9 together give 9. No key gives code 0 with any_key=0.
- FSM states: IDLE, DEBOUNCE, VALID, HELD, RELEASE. A single counter cnt is shared by the states.
- IDLE: if enable_n=0 and any_key=1, capture cand=code, set cnt=0, go to DEBOUNCE.
- DEBOUNCE: if any_key=0 or code≠cand, go to IDLE. If cnt==DEBOUNCE_CYCLES-1, latch key_code=cand and go to VALID. Otherwise increment cnt.
- VALID: key_valid=1. When key_ready=1 at an edge, the transfer occurs; go to HELD with cnt=0. Key release while in VALID does not cancel the event; it is a one-entry buffer.
- HELD: if any_key=0, go to RELEASE with cnt=0. A different key while in HELD is ignored.
- RELEASE: if any_key=1, go back to HELD. If cnt==DEBOUNCE_CYCLES-1, go to IDLE. Otherwise increment cnt.
- enable_n=1 in any state: next edge goes to IDLE, key_valid=0, cnt=0. key_code keeps its last value. The tick divider is unaffected.
- Divider: tcnt runs 0..TICK_DIV-1 and wraps. tick=1 when tcnt==TICK_DIV-1.
- Counter width: $clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_CYCLES and TICK_DIV. No counter saturates past its terminal value.

## Timing
- Reset values: state=IDLE, key_valid=0, key_code=0, cnt=0, tcnt=0, tick=0, strobe_out=0 (given enable_n=0).
- Latency: if the IDLE edge at cycle k samples the key, key_valid is high after edge k+DEBOUNCE_CYCLES. This requires the same code at edges k..k+DEBOUNCE_CYCLES.
- Handshake: key_valid is never deasserted without a transfer, except on enable_n=1 or rst. key_code does not change while key_valid=1.
- Minimum gap between two distinct presses: DEBOUNCE_CYCLES release cycles plus DEBOUNCE_CYCLES press cycles.
- First tick occurs at edge TICK_DIV after reset release.
- Reset asserted mid-operation: immediate clear; any pending event is lost.

## Configuration
- KEYPAD_REPEAT_EN defined: in HELD with any_key=1, cnt increments. When cnt==REPEAT_CYCLES-1, go to VALID and re-issue the same key_code.
- KEYPAD_REPEAT_EN undefined: HELD never re-issues, giving one event per press. REPEAT_CYCLES is ignored, and the counter is sized without it.

## Structure
- Package keypad_pkg holds the state enum type (kp_state_t) and a max-of-three sizing function for counter widths.
- Sub-module tick_div (parameter DIV) contains the tick counter.

## Test plan
Test parameters: NUM_KEYS=10, DEBOUNCE_CYCLES=4, TICK_DIV=5, REPEAT_CYCLES=8.
1. Reset, then idle → all outputs 0. tick pulses at edges 5, 10, 15. strobe_out=tick while enable_n=1.
2. Hold key 7 with key_ready=0 → key_valid=1 and key_code=7 after 4 edges; it stays up. Raise key_ready → one strobe_out pulse. Keep holding for 50 cycles → no further event.
3. Bounce: key 3 high 2 cycles, low 1, high 2, then released → key_valid stays 0 and the FSM returns to IDLE.
4. Keys 2 and 9 pressed together and held → key_code=9. Release for 2 cycles and re-press → no second event. Release for ≥4 cycles and press again → a new event.
5. Raise enable_n while in VALID → key_valid=0 next edge, state IDLE, strobe_out follows tick.
6. With KEYPAD_REPEAT_EN, hold key 5 with key_ready=1 → first event after 4 edges, then events every 9 cycles, all key_code=5. Without the macro → a single event.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the keypad front-end.
// Holds the FSM state type and the counter sizing helper.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    VALID,
    HELD,
    RELEASE
  } kp_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running divider: one-cycle tick every DIV clocks.
// Unaffected by the keypad enable.
module tick_div #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else if (tcnt == LAST) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;
  end

  assign tick = (tcnt == LAST);

endmodule

// File: rtl/keypad_event_encoder.sv
// Priority-encoded, debounced keypad with valid/ready event delivery.
// Define KEYPAD_REPEAT_EN to re-issue a held key every REPEAT_CYCLES.
module keypad_event_encoder
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 100,
  parameter int TICK_DIV        = 100,
  parameter int REPEAT_CYCLES   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enable_n,
  input  logic                key_ready,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  output logic                any_key,
  output logic                tick,
  output logic                strobe_out
);

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_SZ = REPEAT_CYCLES;
`else
  localparam int REP_SZ = 1;
`endif

  localparam int CNT_W =
    $clog2(max3(DEBOUNCE_CYCLES, REP_SZ, TICK_DIV));
  localparam logic [CNT_W-1:0] DEB_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  kp_state_t          state, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CODE_W-1:0]  cand, cand_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic [CODE_W-1:0]  code;
  logic               deb_last;

  tick_div #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Highest index wins; ascending loop lets later keys override.
  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      if (keypad[i]) code = CODE_W'(i);
  end

  assign any_key  = |keypad;
  assign deb_last = (cnt == DEB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      key_code <= '0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_nxt;
      cand     <= cand_nxt;
      key_code <= code_nxt;
    end
  end

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    cand_nxt = cand;
    code_nxt = key_code;
    if (enable_n) begin
      nxt     = IDLE;
      cnt_nxt = '0;
    end else begin
      unique case (state)
        IDLE: if (any_key) begin
          nxt      = DEBOUNCE;
          cand_nxt = code;
          cnt_nxt  = '0;
        end
        DEBOUNCE: if (!any_key || code != cand) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else if (deb_last) begin
          nxt      = VALID;
          code_nxt = cand;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
        VALID: if (key_ready) begin
          nxt     = HELD;
          cnt_nxt = '0;
        end
        HELD: if (!any_key) begin
          nxt     = RELEASE;
          cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
        end else if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
          nxt     = VALID;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
`endif
        end
        RELEASE: if (any_key) begin
          nxt     = HELD;
          cnt_nxt = '0;
        end else if (deb_last) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
        default: begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    key_valid  = (state == VALID);
    strobe_out = enable_n ? tick : (key_valid & key_ready);
  end

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Directed, table-driven bench for keypad_event_encoder.
// Build with or without KEYPAD_REPEAT_EN.
module tb_keypad_event_encoder;

`ifdef KEYPAD_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] keypad = '0;
  logic       enable_n = 1'b0;
  logic       key_ready = 1'b0;
  logic       key_valid;
  logic [3:0] key_code;
  logic       any_key;
  logic       tick;
  logic       strobe_out;

  int checks = 0;
  int fails  = 0;
  int tc;

  keypad_event_encoder #(
    .NUM_KEYS        (10),
    .CODE_W          (4),
    .DEBOUNCE_CYCLES (4),
    .TICK_DIV        (5),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keypad     (keypad),
    .enable_n   (enable_n),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .any_key    (any_key),
    .tick       (tick),
    .strobe_out (strobe_out)
  );

  always #5 clk = ~clk;

  // Reference phase of the divide-by-5 tick.
  always @(posedge clk or posedge rst) begin
    if (rst) tc <= 0;
    else tc <= (tc == 4) ? 0 : tc + 1;
  end

  typedef struct {
    logic [9:0] kp;
    logic       en_n;
    logic       rdy;
    int         n;
    logic       ev;
    logic [3:0] ec;
    logic       ea;
    int         es;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [9:0] kp, input logic en_n,
                     input logic rdy, input int n, input logic ev,
                     input logic [3:0] ec, input logic ea,
                     input int es);
    vec_t v;
    v.kp = kp; v.en_n = en_n; v.rdy = rdy; v.n = n;
    v.ev = ev; v.ec = ec; v.ea = ea; v.es = es;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails + 1);
    $fatal(1);
  end

  initial begin
    int first_ev, prev_ev, n_ev;
    logic exp_s;

    // test 2: single press, held, no repeat
    add(10'h080, 0, 0, 4,  0,   4'd0, 1, 0);
    add(10'h080, 0, 0, 1,  1,   4'd7, 1, 0);
    add(10'h080, 0, 0, 5,  1,   4'd7, 1, 0);
    add(10'h080, 0, 1, 0,  1,   4'd7, 1, 1);
    add(10'h080, 0, 1, 1,  0,   4'd7, 1, 0);
    add(10'h080, 0, 0, 50, REP, 4'd7, 1, 0);
    add(10'h000, 0, 1, 8,  0,   4'd7, 0, 0);
    // test 3: bounce, then a clean press
    add(10'h008, 0, 0, 2, 0, 4'd7, 1, 0);
    add(10'h000, 0, 0, 1, 0, 4'd7, 0, 0);
    add(10'h008, 0, 0, 2, 0, 4'd7, 1, 0);
    add(10'h000, 0, 0, 1, 0, 4'd7, 0, 0);
    add(10'h000, 0, 0, 5, 0, 4'd7, 0, 0);
    add(10'h008, 0, 0, 4, 0, 4'd7, 1, 0);
    add(10'h008, 0, 0, 1, 1, 4'd3, 1, 0);
    add(10'h008, 0, 1, 1, 0, 4'd3, 1, 0);
    add(10'h000, 0, 0, 6, 0, 4'd3, 0, 0);
    // test 4: priority, short release, long release
    add(10'h204, 0, 0, 4, 0, 4'd3, 1, 0);
    add(10'h204, 0, 0, 1, 1, 4'd9, 1, 0);
    add(10'h204, 0, 1, 0, 1, 4'd9, 1, 1);
    add(10'h204, 0, 1, 1, 0, 4'd9, 1, 0);
    add(10'h000, 0, 0, 2, 0, 4'd9, 0, 0);
    add(10'h204, 0, 0, 6, 0, 4'd9, 1, 0);
    add(10'h000, 0, 0, 6, 0, 4'd9, 0, 0);
    add(10'h204, 0, 0, 4, 0, 4'd9, 1, 0);
    add(10'h204, 0, 0, 1, 1, 4'd9, 1, 0);
    // test 5: disable while VALID, then re-press from IDLE
    add(10'h204, 1, 0, 1, 0, 4'd9, 1, 2);
    add(10'h204, 1, 1, 3, 0, 4'd9, 1, 2);
    add(10'h204, 0, 0, 4, 0, 4'd9, 1, 0);
    add(10'h204, 0, 0, 1, 1, 4'd9, 1, 0);
    add(10'h204, 0, 1, 1, 0, 4'd9, 1, 0);
    add(10'h000, 0, 0, 6, 0, 4'd9, 0, 0);

    // test 1: reset values, then tick with enable_n high
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_any", any_key, 0);
    chk("rst_tick", tick, 0);
    chk("rst_strobe", strobe_out, 0);
    enable_n = 1'b1;
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk("tick_phase", tick, (e % 5) == 4);
      chk("strobe_tick", strobe_out, (e % 5) == 4);
      chk("idle_valid", key_valid, 0);
    end
    enable_n = 1'b0;

    foreach (tbl[i]) begin
      keypad    = tbl[i].kp;
      enable_n  = tbl[i].en_n;
      key_ready = tbl[i].rdy;
      #1;
      for (int c = 0; c < tbl[i].n; c++) step();
      exp_s = (tbl[i].es == 2) ? (tc == 4) : tbl[i].es[0];
      chk($sformatf("v%0d_valid", i), key_valid, tbl[i].ev);
      chk($sformatf("v%0d_code", i), key_code, tbl[i].ec);
      chk($sformatf("v%0d_any", i), any_key, tbl[i].ea);
      chk($sformatf("v%0d_strobe", i), strobe_out, exp_s);
    end

    // test 6: hold key 5 with key_ready high, count events
    keypad    = 10'h020;
    key_ready = 1'b1;
    first_ev  = 0;
    prev_ev   = 0;
    n_ev      = 0;
    #1;
    for (int j = 1; j <= 40; j++) begin
      if (key_valid && key_ready) begin
        n_ev++;
        chk("rep_code", key_code, 5);
        if (n_ev == 1) first_ev = j;
        else chk("rep_gap", j - prev_ev, 9);
        prev_ev = j;
      end
      step();
    end
    chk("rep_first", first_ev, 6);
    chk("rep_count", n_ev, REP ? 4 : 1);
    keypad    = '0;
    key_ready = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("rep_idle", key_valid, 0);

    // asynchronous reset with an event pending
    keypad = 10'h010;
    for (int c = 0; c < 5; c++) step();
    chk("pre_rst_valid", key_valid, 1);
    chk("pre_rst_code", key_code, 4);
    #3 rst = 1'b1;
    #1;
    chk("async_valid", key_valid, 0);
    chk("async_code", key_code, 0);
    chk("async_tick", tick, 0);
    #1 rst = 1'b0;
    step();
    chk("post_rst_valid", key_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
